ps2_key_rx: RTL and testbench
=============================

// Module: ps2_key_rx
// PURPOSE
//  PS/2 keyboard receiver feeding the scan-code-to-ASCII converter. Synchronises and
//  de-glitches ps2c/ps2d, deserialises 11-bit frames, and strips F0 (break) and E0
//  (extended) prefixes. Emits the bare key scan code plus one-clk press/release ticks;
//  key_code drives the converter's key_code input directly.
// PARAMETERS
//  FILTER_LEN   8       ps2c glitch-filter depth in clk samples (>=2)
//  TIMEOUT_CYC  200000  clk cycles without a ps2c falling edge before a frame is aborted
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-low reset
//  ps2c         in   1  PS/2 clock line (async)
//  ps2d         in   1  PS/2 data line (async)
//  key_code     out  8  last make/break scan code, prefixes stripped; held until next key
//  key_done     out  1  one-clk tick: key press (make code) accepted
//  key_release  out  1  one-clk tick: key release (F0-prefixed code) accepted
//  key_ext      out  1  E0 prefix preceded the current key_code; valid with either tick
//  rx_err       out  1  one-clk tick: frame discarded (parity/stop/timeout)
// BEHAVIOUR
//  Reset (async, reset=0): key_code=8'h00, key_done=key_release=rx_err=0, key_ext=0,
//   FSM=IDLE, filter shift reg all 1s, filtered clock=1, brk/ext flags=0, timer=0.
//  Input path: ps2c/ps2d through 2-flop synchronisers; ps2c filter shifts in one sample
//   per clk; filtered clock goes 1 when all FILTER_LEN samples are 1, 0 when all are 0,
//   else holds. fall = filtered clock 1->0 (one-clk pulse). ps2d sampled on fall only.
//  FSM:
//   IDLE: on fall with ps2d=0 (start) -> DATA, bit count=0; fall with ps2d=1 ignored.
//   DATA: each fall shifts ps2d in LSB-first into 10-bit reg (8 data, parity, stop);
//    after the 10th -> CHECK. Timer counts clks since last fall; at TIMEOUT_CYC -> IDLE,
//    frame discarded, rx_err tick.
//   CHECK (1 clk): stop must be 1; data+parity must have odd count of 1s. Fail -> rx_err
//    tick, no other output change. Pass -> classify byte, -> IDLE.
//  Classify: 8'hF0 -> set brk, no tick. 8'hE0 -> set ext, no tick. Other byte B:
//   key_code<=B, key_ext<=ext; brk ? key_release tick : key_done tick; clear brk and ext.
//   F0 and E0 in either order before B are both honoured. rx_err clears brk and ext.
//  Latency: tick and key_code update register on the clk after CHECK, i.e. exactly
//   2 clk after the fall pulse of the stop bit. Ticks never overlap; at most one per frame.
//  Typematic repeats of the same make code each yield a key_done tick.
//  Reset mid-frame: frame and pending prefixes are lost; the next start bit after reset
//   is required to decode normally.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined: parity checked as above; failure -> rx_err, frame dropped.
//  Not defined: parity bit captured but ignored; only stop-bit and timeout errors raise
//   rx_err. Ports identical in both builds.
// TESTING
//  Frame 0x1C, parity 0, stop 1 -> key_done 1 clk, key_code=8'h1C, key_ext=0, no rx_err.
//  Frames F0 then 1C -> no tick after F0; key_release 1 clk, key_code=8'h1C, no key_done.
//  Frames E0, F0, 75 -> key_release 1 clk, key_code=8'h75, key_ext=1; next frame 0x16
//   -> key_done, key_ext=0.
//  Frame 0x1C with parity 1 -> EN: rx_err 1 clk, key_code unchanged, no key_done;
//   no EN: key_done, key_code=8'h1C.
//  Start + 5 bits, ps2c held high TIMEOUT_CYC+10 clk -> rx_err 1 clk, no key tick;
//   following clean 0x45 frame -> key_done, key_code=8'h45.
//  2-clk low glitch on ps2c (FILTER_LEN=8) in IDLE -> no state change; reset low after
//   4 bits of a frame -> all outputs at reset values; next 0x16 frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronise/de-glitch ps2c, deserialise frames, strip F0/E0 prefixes.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_key_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] key_code,
  output logic       key_done,
  output logic       key_release,
  output logic       key_ext,
  output logic       rx_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t                state_q, state_d;
  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  logic                  fall;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [9:0]            shift_q, shift_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  timeout;
  logic                  brk_q, brk_d, ext_q, ext_d;
  logic [7:0]            key_code_q, key_code_d;
  logic                  key_ext_q, key_ext_d;
  logic                  done_q, done_d, release_q, release_d, err_q, err_d;
  logic                  parity_ok, frame_ok;

  // Filtered clock only moves when the whole window agrees; otherwise it holds.
  always_comb begin
    filt_d = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};
    fclk_d = fclk_q;
    if (&filt_q)       fclk_d = 1'b1;
    else if (~|filt_q) fclk_d = 1'b0;
  end

  assign fall    = fclk_q & ~fclk_d;
  assign timeout = (timer_q == TW'(TIMEOUT_CYC));

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[8:0];
`else
  assign parity_ok = 1'b1;
`endif
  assign frame_ok = shift_q[9] & parity_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall && !d_sync_q[1]) state_d = DATA;
      DATA: begin
        if (fall) begin
          if (bit_cnt_q == 4'd9) state_d = CHECK;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    timer_d    = timer_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    key_code_d = key_code_q;
    key_ext_d  = key_ext_q;
    done_d     = 1'b0;
    release_d  = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall && !d_sync_q[1]) bit_cnt_d = '0;
      end
      DATA: begin
        if (fall) begin
          shift_d   = {d_sync_q[1], shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
        end else if (timeout) begin
          err_d = 1'b1;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      CHECK: begin
        if (!frame_ok) begin
          err_d = 1'b1;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else if (shift_q[7:0] == 8'hF0) begin
          brk_d = 1'b1;
        end else if (shift_q[7:0] == 8'hE0) begin
          ext_d = 1'b1;
        end else begin
          key_code_d = shift_q[7:0];
          key_ext_d  = ext_q;
          done_d     = ~brk_q;
          release_d  = brk_q;
          brk_d      = 1'b0;
          ext_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_sync_q   <= '1;
      d_sync_q   <= '1;
      filt_q     <= '1;
      fclk_q     <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      key_code_q <= '0;
      key_ext_q  <= 1'b0;
      done_q     <= 1'b0;
      release_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      c_sync_q   <= {c_sync_q[0], ps2c};
      d_sync_q   <= {d_sync_q[0], ps2d};
      filt_q     <= filt_d;
      fclk_q     <= fclk_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      key_code_q <= key_code_d;
      key_ext_q  <= key_ext_d;
      done_q     <= done_d;
      release_q  <= release_d;
      err_q      <= err_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_done    = done_q;
  assign key_release = release_q;
  assign key_ext     = key_ext_q;
  assign rx_err      = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: byte-level event model with a per-cycle compare process.
module tb_ps2_key_rx;

  localparam int F    = 8;
  localparam int TO   = 600;
  localparam int HALF = 20;
  localparam int LAT  = F + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] key_code;
  logic       key_done, key_release, key_ext, rx_err;

  ps2_key_rx #(.FILTER_LEN(F), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .key_code(key_code), .key_done(key_done), .key_release(key_release),
    .key_ext(key_ext), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // kind: 0 = key_done, 1 = key_release, 2 = rx_err; due = exact cycle (0 = not pinned)
  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    int         due;
    int         deadline;
  } ev_t;

  ev_t        q[$];
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;
  logic [7:0] cur_code = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int stop_cyc);
    ev_t e;
    bit  bad;
    e.due = stop_cyc + LAT;
    e.deadline = e.due;
    e.code = b;
    e.ext = 1'b0;
    bad = bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    bad = bad | bad_par;
`endif
    if (bad) begin
      e.kind = 2;
      q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      e.kind = m_brk ? 1 : 0;
      e.ext = m_ext;
      q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2d = fr[i];
      repeat (HALF) @(negedge clk);
      ps2c = 1'b0;
      if (i == 10) model_frame(b, bad_par, bad_stop, cyc);
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
    end
    if (nbits == 11) begin
      @(negedge clk) ps2d = 1'b1;
      repeat (60) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b0, 11);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_code"}, int'(key_code), 0);
    chk({tag, "_done"}, int'(key_done), 0);
    chk({tag, "_rel"},  int'(key_release), 0);
    chk({tag, "_ext"},  int'(key_ext), 0);
    chk({tag, "_err"},  int'(rx_err), 0);
  endtask

  int  nt;
  int  kind_act;
  ev_t e_cmp;

  always @(negedge clk) begin
    if (reset) begin
      nt = int'(key_done) + int'(key_release) + int'(rx_err);
      if (nt > 1) chk("tick_overlap", nt, 1);
      if (nt >= 1) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", int'({rx_err, key_release, key_done}), 0);
        end else begin
          e_cmp = q.pop_front();
          kind_act = rx_err ? 2 : (key_release ? 1 : 0);
          chk("tick_kind", kind_act, e_cmp.kind);
          if (e_cmp.due != 0) chk("tick_latency", cyc, e_cmp.due);
          if (e_cmp.kind != 2) begin
            chk("key_code", int'(key_code), int'(e_cmp.code));
            chk("key_ext", int'(key_ext), int'(e_cmp.ext));
            cur_code = e_cmp.code;
          end else begin
            chk("code_held_err", int'(key_code), int'(cur_code));
          end
        end
      end else begin
        chk("code_held", int'(key_code), int'(cur_code));
        if (q.size() > 0 && cyc > q[0].deadline) begin
          chk("missing_tick", -1, q[0].kind);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [7:0] b;
    bit         bp, bs;
    ev_t        e;

    repeat (8) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (20) @(negedge clk);

    send(8'h1C);
    chk("lit_1c_code", int'(key_code), 8'h1C);
    chk("lit_1c_ext", int'(key_ext), 0);

    send(8'hF0);
    send(8'h1C);
    chk("lit_brk_code", int'(key_code), 8'h1C);

    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("lit_ext_code", int'(key_code), 8'h75);
    chk("lit_ext_flag", int'(key_ext), 1);
    send(8'h16);
    chk("lit_16_code", int'(key_code), 8'h16);
    chk("lit_16_ext", int'(key_ext), 0);

    send_bits(8'h1C, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
    chk("lit_par_code", int'(key_code), 8'h16);
`else
    chk("lit_par_code", int'(key_code), 8'h1C);
`endif

    send(8'hF0);
    send_bits(8'h45, 1'b0, 1'b0, 6);
    e.kind = 2; e.code = 8'h00; e.ext = 1'b0; e.due = 0;
    e.deadline = cyc + TO + 60;
    q.push_back(e);
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (TO + 10) @(negedge clk);
    repeat (60) @(negedge clk);
    chk("timeout_seen", q.size(), 0);
    send(8'h45);
    chk("lit_45_code", int'(key_code), 8'h45);

    @(negedge clk) ps2d = 1'b0;
    ps2c = 1'b0;
    repeat (2) @(negedge clk);
    ps2c = 1'b1;
    repeat (40) @(negedge clk);
    ps2d = 1'b1;
    repeat (40) @(negedge clk);
    send(8'h16);
    chk("lit_glitch_code", int'(key_code), 8'h16);

    send(8'hF0);
    send_bits(8'h33, 1'b0, 1'b0, 4);
    reset = 1'b0;
    q.delete();
    m_brk = 1'b0;
    m_ext = 1'b0;
    cur_code = 8'h00;
    repeat (5) @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b1;
    repeat (30) @(negedge clk);
    send(8'h16);
    chk("lit_post_rst_code", int'(key_code), 8'h16);

    for (int n = 0; n < 60; n++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 20)      b = 8'hF0;
      else if ($urandom_range(0, 99) < 15) b = 8'hE0;
      else if (b == 8'hF0 || b == 8'hE0)   b = 8'h2A;
      bp = ($urandom_range(0, 99) < 8);
      bs = ($urandom_range(0, 99) < 5);
      send_bits(b, bp, bs, 11);
    end

    repeat (100) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
